mat_mult_seq: RTL and testbench

- Sequenced 2x2 matrix multiplier: one shared WIDTH x WIDTH multiplier and one accumulator, time-multiplexed over the 8 partial products.
- Replaces the 8 parallel multipliers and adders in area-constrained builds.
- Sits between an operand source and a result consumer; valid/ready handshake on both sides.
- Controller FSM sequences operand selection, the multiply pipeline, accumulation and result hold.

---
 rtl/mat_mult_seq.sv | 109 ++++++++++
 tb/tb_mat_mult_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mat_mult_seq.sv
// Sequenced 2x2 matrix multiplier: one shared multiplier and one accumulator
// stepped over the eight partial products, with valid/ready on both sides.
module mat_mult_seq #(
  parameter int WIDTH = 8,
  parameter int RES_W = 2*WIDTH+1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*WIDTH-1:0]   A,
  input  logic [4*WIDTH-1:0]   B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*RES_W-1:0]   Res,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [2:0]           step;
  logic [4*WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0]   prod_reg;
  logic                 prod_vld;
  logic [2:0]           prod_step;
  logic [2*WIDTH-1:0]   acc;
  logic [RES_W-1:0]     res_q [4];
  logic [1:0]           a_idx, b_idx;
  logic [WIDTH-1:0]     a_op, b_op;
  logic [2*WIDTH-1:0]   mult;
  logic                 accept;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (step == 3'd7) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Step s picks element e = s[2:1] (i = s[2], j = s[1]) and inner index k = s[0].
  always_comb begin
    a_idx = {step[2], step[0]};
    b_idx = {step[0], step[1]};
    a_op  = a_reg[WIDTH*(3-int'(a_idx)) +: WIDTH];
    b_op  = b_reg[WIDTH*(3-int'(b_idx)) +: WIDTH];
    mult  = {{WIDTH{1'b0}}, a_op} * {{WIDTH{1'b0}}, b_op};
  end

  // The accumulate stage trails the multiply by one cycle, tagged with its step.
  always_ff @(posedge clk) begin
    if (reset) begin
      step      <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      prod_reg  <= '0;
      prod_vld  <= 1'b0;
      prod_step <= '0;
      acc       <= '0;
      for (int n = 0; n < 4; n++) res_q[n] <= '0;
    end else begin
      prod_vld <= (state == MAC);
      if (state == MAC) begin
        prod_reg  <= mult;
        prod_step <= step;
        step      <= step + 3'd1;
      end
      if (accept) begin
        a_reg <= A;
        b_reg <= B;
        step  <= '0;
        for (int n = 0; n < 4; n++) res_q[n] <= '0;
      end
      if (prod_vld) begin
        if (!prod_step[0]) acc <= prod_reg;
        else res_q[prod_step[2:1]] <= RES_W'(acc) + RES_W'(prod_reg);
      end
    end
  end

  assign Res = {res_q[0], res_q[1], res_q[2], res_q[3]};

endmodule

// File: tb/tb_mat_mult_seq.sv
// Randomized scoreboard bench for mat_mult_seq: the driver queues expected
// products from a plain-arithmetic model, the monitor checks each result.
module tb_mat_mult_seq;

  localparam int W  = 8;
  localparam int RW = 2*W+1;

  typedef struct {
    logic [4*RW-1:0] res;
    int              t;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4*W-1:0]  A, B;
  logic [4*RW-1:0] Res;

  exp_t sbq[$];
  int   errors = 0, checks = 0, cyc = 0, hs_cyc = -1, last_acc = 0;
  logic rand_ready = 1'b0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mat_mult_seq #(.WIDTH(W), .RES_W(RW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Res(Res), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4*RW-1:0] refModel(input logic [4*W-1:0] a, input logic [4*W-1:0] b);
    int unsigned     ae[4], be[4], r;
    logic [4*RW-1:0] res;
    res = '0;
    for (int n = 0; n < 4; n++) begin
      ae[n] = a[W*(3-n) +: W];
      be[n] = b[W*(3-n) +: W];
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        r = ae[2*i]*be[j] + ae[2*i+1]*be[2+j];
        res[RW*(3-(2*i+j)) +: RW] = RW'(r);
      end
    return res;
  endfunction

  // Every cycle a result is shown it must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got %0h, expected no result (cycle %0d)", Res, cyc);
      end else begin
        checkOutput("res_data", 128'(Res), 128'(sbq[0].res));
        if (!prev_valid) checkOutput("latency", 128'(cyc - sbq[0].t), 128'd10);
        if (out_ready) begin
          hs_cyc = cyc;
          void'(sbq.pop_front());
        end
      end
    end
    prev_valid = out_valid;
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic applyStimulus(input logic [4*W-1:0] a, input logic [4*W-1:0] b);
    bit accepted;
    accepted = 1'b0;
    A = a;
    B = b;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back('{refModel(a, b), cyc});
        last_acc = cyc;
        accepted = 1'b1;
      end
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no in_ready, expected acceptance within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 400 && sbq.size() != 0; n++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_in_ready"},  128'(in_ready),  128'd1);
    checkOutput({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    checkOutput({tag, "_busy"},      128'(busy),      128'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    checkOutput("reset_res", 128'(Res), 128'd0);
    @(posedge clk); #1 reset = 1'b0;

    applyStimulus(32'h01020304, 32'h01000001);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("mac_busy", 128'(busy), 128'd1);
    checkOutput("mac_in_ready", 128'(in_ready), 128'd0);
    waitDrain();
    applyStimulus(32'h01020304, 32'h05060708);
    in_valid = 1'b0;
    waitDrain();
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF);
    in_valid = 1'b0;
    waitDrain();

    // Consumer stall: result and flags must hold until the handshake.
    out_ready = 1'b0;
    applyStimulus($urandom, $urandom);
    in_valid = 1'b0;
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    checkOutput("stall_seen", 128'(out_valid), 128'd1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_valid", 128'(out_valid), 128'd1);
      checkOutput("stall_in_ready", 128'(in_ready), 128'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkIdleOutputs("post_hs");
    waitDrain();

    // Abort mid-operation, then a spurious in_valid while busy.
    applyStimulus($urandom, $urandom);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    sbq.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("abort");
    @(posedge clk); #1;
    applyStimulus($urandom, $urandom);
    A = $urandom; B = $urandom; in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("busy_in_ready", 128'(in_ready), 128'd0);
      checkOutput("busy_flag", 128'(busy), 128'd1);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    waitDrain();

    // Back-to-back: second accept lands the cycle after the first handshake.
    applyStimulus($urandom, $urandom);
    applyStimulus($urandom, $urandom);
    in_valid = 1'b0;
    checkOutput("b2b_accept", 128'(last_acc), 128'(hs_cyc + 1));
    waitDrain();

    rand_ready = 1'b1;
    for (int n = 0; n < 15; n++) begin
      applyStimulus($urandom, $urandom);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    rand_ready = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    waitDrain();

    repeat (30) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 400000 time units");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
